// File: rtl/bar_pkg.sv
// bar_pkg: shared types and constants for the bar-graph level controller.
//   btn_state_t : button FSM states (IDLE, DELAY, REPEAT)
//   LEVEL_W     : width of the half-step level register
//   LEVEL_MAX   : highest half-step level (7 rows x 2 half-steps)
package bar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int LEVEL_W = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd14;

endpackage

// File: rtl/blink_gen.sv
// blink_gen: blink-phase prescaler for the bar-graph top row.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   restart : restart the blink so the next phase is a full "on" half-period
//   phase   : 1 = top row lit, 0 = top row dark; toggles every BLINK_HALF cycles
module blink_gen #(
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase
);
    localparam int BCNT_W = $clog2(BLINK_HALF);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_HALF - 1);

    logic [BCNT_W-1:0] bcnt;

    // restart beats a same-edge wrap so a new odd level is shown immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (restart) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BCNT_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt  <= bcnt + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/bar_level_ctrl.sv
// bar_level_ctrl: half-step fill level (0..14) driven by debounced up/down
// buttons with hold-to-repeat, feeding the 7-row bar-graph decoder.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   inc, dec   : debounced up/down buttons, active high
//   clear      : synchronous clear to level 0, beats inc/dec
//   count      : level[3:1], decoder row count
//   blink      : level[0] & blink phase, decoder blink input
//   level      : current half-step level
//   full/empty : level at 14 / level at 0
module bar_level_ctrl
    import bar_pkg::*;
#(
    parameter int BLINK_HALF = 25_000_000,
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    input  logic               clear,
    output logic [2:0]         count,
    output logic               blink,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);
    localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYC - 1);

    btn_state_t         state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic               dir, dir_nxt;       // 1 = inc is the active button
    logic               armed, armed_nxt;   // low after clear until both buttons released
    logic [LEVEL_W-1:0] level_nxt;
    logic               held, other, restart, phase;

    function automatic logic [LEVEL_W-1:0] step_level(input logic [LEVEL_W-1:0] lv,
                                                      input logic up);
        if (up)
            return (lv >= LEVEL_MAX) ? LEVEL_MAX : lv + LEVEL_W'(1);
        else
            return (lv == '0) ? '0 : lv - LEVEL_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        dir_nxt   = dir;
        armed_nxt = armed;
        level_nxt = level;
        held      = dir ? inc : dec;
        other     = dir ? dec : inc;
        if (clear) begin
            level_nxt = '0;
            state_nxt = IDLE;
            tmr_nxt   = '0;
            armed_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!inc && !dec)
                        armed_nxt = 1'b1;
                    if (armed && (inc ^ dec)) begin
                        level_nxt = step_level(level, inc);
                        dir_nxt   = inc;
                        tmr_nxt   = HOLD_LOAD;
                        state_nxt = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!held || other) begin
                        state_nxt = IDLE;
                    end else if (tmr == '0) begin
                        // keeps timing while saturated; step_level holds the end value
                        level_nxt = step_level(level, dir);
                        tmr_nxt   = REPEAT_LOAD;
                        state_nxt = REPEAT;
                    end else begin
                        tmr_nxt   = tmr - TMR_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
            dir   <= 1'b0;
            armed <= 1'b1;
            level <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            dir   <= dir_nxt;
            armed <= armed_nxt;
            level <= level_nxt;
        end
    end

    // a saturated step leaves level unchanged and must not restart the blink
    assign restart = clear | (level_nxt != level);

    blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .phase  (phase)
    );

    assign count = level[3:1];
    assign blink = level[0] & phase;
    assign full  = (level == LEVEL_MAX);
    assign empty = (level == '0);

endmodule

// File: tb/tb_bar_level_ctrl.sv
module tb_bar_level_ctrl;

    localparam int BH   = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic       clk = 1'b0;
    logic       rst_n, inc, dec, clear;
    logic [2:0] count;
    logic       blink, full, empty;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;

    bar_level_ctrl #(.BLINK_HALF(BH), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clear(clear),
        .count(count), .blink(blink), .level(level), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: level rules expressed as hold age and time since restart.
    int m_lvl, m_age, m_since;
    bit m_active, m_up, m_need_rel;

    function automatic int sat(input int v);
        return (v < 0) ? 0 : (v > 14) ? 14 : v;
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_age = 0; m_since = 0;
        m_active = 0; m_up = 0; m_need_rel = 0;
    endtask

    task automatic model_edge(input bit i, input bit d, input bit c);
        int nl;
        bit rs;
        nl = m_lvl;
        rs = 0;
        if (c) begin
            nl = 0; rs = 1; m_active = 0; m_need_rel = 1;
        end else if (!m_active) begin
            if (!i && !d) m_need_rel = 0;
            else if (!m_need_rel && (i != d)) begin
                m_up = i; m_active = 1; m_age = 0;
                nl = sat(m_lvl + (i ? 1 : -1));
            end
        end else begin
            if (!(m_up ? i : d) || (m_up ? d : i)) m_active = 0;
            else begin
                m_age++;
                if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
                    nl = sat(m_lvl + (m_up ? 1 : -1));
            end
        end
        if (nl != m_lvl) rs = 1;
        m_lvl   = nl;
        m_since = rs ? 0 : m_since + 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int eb;
        eb = ((m_lvl % 2) == 1 && ((m_since / BH) % 2) == 0) ? 1 : 0;
        chk({tag, ".level"}, level, m_lvl);
        chk({tag, ".count"}, count, m_lvl / 2);
        chk({tag, ".blink"}, blink, eb);
        chk({tag, ".full"},  full,  (m_lvl == 14) ? 1 : 0);
        chk({tag, ".empty"}, empty, (m_lvl == 0) ? 1 : 0);
    endtask

    task automatic cyc(input bit i, input bit d, input bit c, input string tag);
        @(negedge clk);
        inc = i; dec = d; clear = c;
        @(posedge clk);
        model_edge(i, d, c);
        #1;
        check_model(tag);
    endtask

    task automatic pulses(input bit up, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(up, !up, 1'b0, "pulse");
            cyc(1'b0, 1'b0, 1'b0, "pulse_rel");
        end
    endtask

    typedef struct {
        bit i, d, c;
        int lvl;
        int blk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit i, input bit d, input bit c, input int l, input int b);
        vec_t v;
        v.i = i; v.d = d; v.c = c; v.lvl = l; v.blk = b;
        vecs.push_back(v);
    endfunction

    initial begin
        bit ri, rd, rc;
        int hl;

        // single step, then blink on 4 / off 4 / on again
        add(1, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        // hold inc 20 cycles from 0: steps at 0, 8, 11, 14, 17
        for (int j = 0; j < 20; j++) begin
            hl = (j < 8) ? 1 : (j < 11) ? 2 : (j < 14) ? 3 : (j < 17) ? 4 : 5;
            add(1, 0, 0, hl, (j < 4) || (j >= 11 && j < 14) || (j >= 17));
        end
        add(0, 0, 0, 5, 1);

        rst_n = 1'b0; inc = 0; dec = 0; clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.level", level, 0);
        chk("reset.count", count, 0);
        chk("reset.blink", blink, 0);
        chk("reset.full",  full,  0);
        chk("reset.empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            cyc(vecs[n].i, vecs[n].d, vecs[n].c, "vec");
            chk("vec.level", level, vecs[n].lvl);
            chk("vec.blink", blink, vecs[n].blk);
        end

        // saturation at the top
        cyc(0, 0, 1, "sat_clr");
        cyc(0, 0, 0, "sat_rel");
        pulses(1, 13);
        chk("sat.pre13", level, 13);
        for (int k = 0; k < 30; k++) cyc(1, 0, 0, "sat_hold");
        chk("sat.level", level, 14);
        chk("sat.full",  full,  1);
        chk("sat.count", count, 7);
        chk("sat.blink", blink, 0);
        cyc(0, 0, 0, "sat_rel");

        // conflicting buttons
        cyc(0, 0, 1, "cf_clr");
        cyc(0, 0, 0, "cf_rel");
        pulses(1, 6);
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, "cf_both");
        chk("conflict.same_edge", level, 6);
        cyc(0, 0, 0, "cf_rel");
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, "cf_inc");
        for (int k = 0; k < 12; k++) cyc(1, 1, 0, "cf_dec_rise");
        chk("conflict.dec_rise", level, 7);
        cyc(0, 0, 0, "cf_rel");

        // clear priority and release/re-press
        pulses(1, 2);
        chk("clr.pre9", level, 9);
        cyc(1, 0, 1, "clr_inc");
        chk("clr.level", level, 0);
        chk("clr.empty", empty, 1);
        chk("clr.blink", blink, 0);
        for (int k = 0; k < 12; k++) cyc(1, 0, 0, "clr_hold");
        chk("clr.no_step", level, 0);
        cyc(0, 0, 0, "clr_rel");
        cyc(1, 0, 0, "clr_repress");
        chk("clr.repress", level, 1);
        cyc(0, 0, 0, "clr_rel2");

        // async reset during REPEAT at level 7
        pulses(1, 4);
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, "ar_hold");
        chk("areset.pre", level, 7);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset.level", level, 0);
        chk("areset.empty", empty, 1);
        chk("areset.blink", blink, 0);
        chk("areset.count", count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1, 0, 0, "ar_first");
        chk("areset.first_step", level, 1);
        cyc(0, 0, 0, "ar_rel");

        // randomized run against the model
        ri = 0; rd = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) ri = !ri;
            if ($urandom_range(0, 9) == 0) rd = !rd;
            rc = ($urandom_range(0, 99) == 0);
            cyc(ri, rd, rc, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bar_level_ctrl.md
# bar_level_ctrl

Sequencing controller for the 7-row bar-graph decoder. Keeps a half-step fill level from 0 to 14, driven by debounced up/down buttons with hold-to-repeat. Drives the decoder's 3-bit `count` and its `blink` input, so odd half-levels show as a blinking top row. It sits between the button debouncers and the row decoder, and also exports `full`/`empty` flags for the status LEDs.

## Interface
- `BLINK_HALF`, 25_000_000 — clock cycles per blink phase (on or off half-period); ≥ 2.
- `HOLD_CYC`, 50_000_000 — cycles a button must stay held before auto-repeat starts; ≥ 2.
- `REPEAT_CYC`, 10_000_000 — cycles between auto-repeat steps; ≥ 2.
- `clk` in 1 — single clock; all state on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `inc` in 1 — debounced up button, synchronous level, active high.
- `dec` in 1 — debounced down button, synchronous level, active high.
- `clear` in 1 — synchronous clear to level 0; has priority over `inc`/`dec`.
- `count` out 3 — `level[3:1]`, to the decoder `count` input.
- `blink` out 1 — `level[0] & phase`, to the decoder `blink` input.
- `level` out 4 — current half-step level, 0..14.
- `full` out 1 — `level == 14`.
- `empty` out 1 — `level == 0`.

## Operation
- Button FSM states: `IDLE`, `DELAY`, `REPEAT`. `dir` is a register that records whether the active button is `inc` or `dec`.
- In `IDLE`:
  - If exactly one of `inc`/`dec` is high: take one step in that direction, load `tmr = HOLD_CYC-1`, and go to `DELAY`.
  - If both are high, or neither: no step; stay in `IDLE`.
- In `DELAY` and `REPEAT`:
  - If the button recorded in `dir` drops, or the other button rises: go to `IDLE` with no step.
  - Otherwise, when `tmr == 0`: take a step, reload `tmr = REPEAT_CYC-1`, and go to (or stay in) `REPEAT`.
  - Otherwise decrement `tmr`.
- Stepping saturates at both ends:
  - Up at 14 stays at 14; down at 0 stays at 0.
  - The FSM keeps timing while saturated.
- `clear` sets level to 0 and the FSM to `IDLE`. A button still held after `clear` needs release and re-press to step again.
- Blink generator:
  - Counter `bcnt` runs 0..`BLINK_HALF-1`; `phase` toggles when it wraps.
  - Any change in level, including `clear`, forces `bcnt = 0` and `phase = 1`, so a new odd level shows its top row immediately.
  - A saturated step that leaves the level unchanged does not restart the blink.
- Width rules: level is 4 bits unsigned and values 15 never occur. `tmr` width is `$clog2(max(HOLD_CYC, REPEAT_CYC))`.

## Timing
- All outputs are registered or are decoded from registers only. There is no combinational path from any input to any output.
- Reset values: level = 0, `count` = 0, `blink` = 0, `full` = 0, `empty` = 1, state = `IDLE`, `tmr` = 0, `bcnt` = 0, `phase` = 1.
- Step latency: a button first sampled high at edge k (in `IDLE`) updates `level` after edge k, so it is visible in cycle k+1.
- First repeat step comes at edge k+`HOLD_CYC`. Later repeats come every `REPEAT_CYC` edges.
- Reset mid-hold: the next step after `rst_n` deasserts needs the button sampled high in `IDLE`. A button held through reset therefore steps on the first active edge.
- Same-edge events:
  - `clear` with a step: `clear` wins.
  - Level change with blink wrap: the level-change restart wins.

## Structure
- Package `bar_pkg`:
  - `btn_state_t` enum (`IDLE`, `DELAY`, `REPEAT`)
  - `LEVEL_MAX = 4'd14`
  - `LEVEL_W = 4`
- Sub-module `blink_gen` (params `BLINK_HALF`; ports `clk`, `rst_n`, `restart`, `phase`) holds the prescaler.
- The button FSM, level register and output decode stay in `bar_level_ctrl`.

## Test plan
All scenarios use `BLINK_HALF=4`, `HOLD_CYC=8`, `REPEAT_CYC=3`.
- **Reset and single step:** release reset, then pulse `inc` for 1 cycle → `level` = 1, `count` = 0, `blink` = 1 for 4 cycles then 0 for 4 cycles, repeating; `empty` = 0.
- **Hold repeat:** hold `inc` for 20 cycles from level 0 → steps at edges 0, 8, 11, 14, 17; final `level` = 5, `count` = 2.
- **Saturation:** hold `inc` from level 13 → `level` = 14, `full` = 1, `count` = 7, `blink` = 0; further repeats leave it at 14 and the blink phase is not restarted.
- **Conflicting buttons:**
  - `inc` and `dec` rise on the same edge at level 6 → no change, FSM stays `IDLE`.
  - `dec` rising during an `inc` hold → `IDLE`, level unchanged.
- **Clear priority:** at level 9, assert `clear` and `inc` together → `level` = 0, `empty` = 1, `blink` = 0; `inc` held afterwards produces no step until it is released and re-pressed.
- **Async reset mid-repeat:** drop `rst_n` for 1 cycle during `REPEAT` at level 7 → outputs go to reset values immediately; with `inc` still held, `level` = 1 after the first active edge.
